// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial line in, byte/strobe/status out.
interface uart_rx_if;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    modport master (
        input  rx_serial,
        output rx_byte, rx_byte_valid, frame_error, parity_error, busy
    );

    modport slave (
        output rx_serial,
        input  rx_byte, rx_byte_valid, frame_error, parity_error, busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with live parity_error.
// Mid-bit sampling off a 2-flop synchronised line, one-cycle registered strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FLUSH   = CW'(2);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    byte_q, byte_n;
    logic          valid_q, valid_n;
    logic          ferr_q, ferr_n;
    logic          busy_q;
    logic          sync1, rxs;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_bad_n;
    logic          perr_q, perr_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= bus.rx_serial;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            byte_q  <= byte_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            busy_q  <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
            perr_q  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        idx_n     = idx;
        shift_n   = shift;
        byte_n    = byte_q;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        unique case (state)
            // The synchroniser resets to ones that do not reflect the pin; let them
            // flush before trusting rxs=1, so a line held low across reset is not idle.
            WAIT_IDLE: begin
                if (cnt != FLUSH) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = cnt;
                    if (rxs) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    idx_n     = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_n = 1'b0;
`endif
                    state_n   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rxs;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    par_bad_n = ^{shift, rxs};
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (!rxs) begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end else begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            perr_n = 1'b1;
                        end else begin
                            valid_n = 1'b1;
                            byte_n  = shift;
                        end
`else
                        valid_n = 1'b1;
                        byte_n  = shift;
`endif
                    end
                end
            end
            default: begin
                state_n = WAIT_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.rx_byte       = byte_q;
    assign bus.rx_byte_valid = valid_q;
    assign bus.frame_error   = ferr_q;
    assign bus.busy          = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error  = perr_q;
`else
    assign bus.parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=8; parity cases only with UART_RX_PARITY_EN.
module tb_uart_rx;
    localparam int C    = 8;
    localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT = 2 + HALF + (9 + P) * C + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(C)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int       nvalid = 0, nferr = 0, nperr = 0, nbusy = 0;
    int       hist_cyc [0:63];
    logic [7:0] hist_byte [0:63];

    always @(negedge clk) begin
        if (bus.rx_byte_valid === 1'b1) begin
            if (nvalid < 64) begin
                hist_cyc[nvalid]  = cyc;
                hist_byte[nvalid] = bus.rx_byte;
            end
            nvalid++;
        end
        if (bus.frame_error === 1'b1) nferr++;
        if (bus.parity_error === 1'b1) nperr++;
        if (bus.busy === 1'b1) nbusy++;
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, output int start_cyc);
        start_cyc = cyc;
        bus.rx_serial = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_serial = b[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx_serial = par;
        repeat (C) @(negedge clk);
`else
        if (par !== par) bus.rx_serial = 1'bx;
`endif
        bus.rx_serial = stop;
        repeat (C) @(negedge clk);
    endtask

    int d0, d1, v0, f0, p0, b0;

    initial begin
        bus.rx_serial = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_rx_byte", 32'(bus.rx_byte), 32'h00);
        check("reset_valid", 32'(bus.rx_byte_valid), 32'd0);
        check("reset_ferr", 32'(bus.frame_error), 32'd0);
        check("reset_perr", 32'(bus.parity_error), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        idle(20);

        // single 0xA5 frame
        v0 = nvalid; f0 = nferr; p0 = nperr;
        send_frame(8'hA5, 1'b0, 1'b1, d0);
        idle(10);
        check("a5_count", 32'(nvalid - v0), 32'd1);
        check("a5_time", 32'(hist_cyc[v0] - d0), 32'(LAT));
        check("a5_byte", 32'(bus.rx_byte), 32'hA5);
        check("a5_ferr", 32'(nferr - f0), 32'd0);
        check("a5_perr", 32'(nperr - p0), 32'd0);

        // back-to-back 0x00 then 0xFF
        v0 = nvalid;
        send_frame(8'h00, 1'b0, 1'b1, d0);
        send_frame(8'hFF, 1'b0, 1'b1, d1);
        idle(10);
        check("b2b_count", 32'(nvalid - v0), 32'd2);
        check("b2b_first", 32'(hist_byte[v0]), 32'h00);
        check("b2b_second", 32'(hist_byte[v0 + 1]), 32'hFF);
        check("b2b_spacing", 32'(hist_cyc[v0 + 1] - hist_cyc[v0]), 32'((10 + P) * C));
        check("b2b_time", 32'(hist_cyc[v0] - d0), 32'(LAT));

        // 3-cycle glitch while idle
        v0 = nvalid; f0 = nferr; p0 = nperr; b0 = nbusy;
        bus.rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        check("glitch_busy_seen", 32'(nbusy != b0), 32'd1);
        check("glitch_busy_now", 32'(bus.busy), 32'd0);
        check("glitch_valid", 32'(nvalid - v0), 32'd0);
        check("glitch_ferr", 32'(nferr - f0), 32'd0);
        check("glitch_byte", 32'(bus.rx_byte), 32'hFF);

        // framing error then a good frame
        v0 = nvalid; f0 = nferr; p0 = nperr;
        send_frame(8'h3C, 1'b0, 1'b0, d0);
        idle(20);
        check("ferr_count", 32'(nferr - f0), 32'd1);
        check("ferr_valid", 32'(nvalid - v0), 32'd0);
        check("ferr_perr", 32'(nperr - p0), 32'd0);
        check("ferr_byte", 32'(bus.rx_byte), 32'hFF);
        send_frame(8'h81, 1'b0, 1'b1, d0);
        idle(10);
        check("post_ferr_valid", 32'(nvalid - v0), 32'd1);
        check("post_ferr_byte", 32'(bus.rx_byte), 32'h81);

        // reset during data bit 3 with the line held low afterwards
        v0 = nvalid; f0 = nferr; p0 = nperr;
        bus.rx_serial = 1'b0;
        repeat (C + 3 * C + HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        idle(40);
        check("abort_valid", 32'(nvalid - v0), 32'd0);
        check("abort_ferr", 32'(nferr - f0), 32'd0);
        check("abort_byte", 32'(bus.rx_byte), 32'h00);
        send_frame(8'h42, 1'b0, 1'b1, d0);
        idle(10);
        check("after_abort_valid", 32'(nvalid - v0), 32'd1);
        check("after_abort_byte", 32'(bus.rx_byte), 32'h42);
        check("after_abort_time", 32'(hist_cyc[v0] - d0), 32'(LAT));

`ifdef UART_RX_PARITY_EN
        v0 = nvalid; p0 = nperr;
        send_frame(8'h07, 1'b1, 1'b1, d0);
        idle(10);
        check("par_ok_valid", 32'(nvalid - v0), 32'd1);
        check("par_ok_byte", 32'(bus.rx_byte), 32'h07);
        check("par_ok_perr", 32'(nperr - p0), 32'd0);
        send_frame(8'h07, 1'b0, 1'b1, d0);
        idle(10);
        check("par_bad_perr", 32'(nperr - p0), 32'd1);
        check("par_bad_valid", 32'(nvalid - v0), 32'd1);
        check("par_bad_byte", 32'(bus.rx_byte), 32'h07);
`else
        check("no_parity_strobes", 32'(nperr), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-byte UART receiver feeding the instruction-load collector. Synchronises the asynchronous `rx_serial` pin, detects and validates start bits, samples 8N1 frames (optionally 8E1) at mid-bit, and emits each received byte with a one-cycle valid strobe. The collector assembles four consecutive bytes into an instruction word.

## Interface
- `CLKS_PER_BIT`, default 868, is the number of `clk` cycles per bit (100 MHz / 115200). Must be ≥ 4.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `rx_serial`  in  1  asynchronous serial line, idle high
- `rx_byte`  out  8  last received byte; holds until the next valid byte
- `rx_byte_valid`  out  1  one-cycle strobe; `rx_byte` is valid in the same cycle
- `frame_error`  out  1  one-cycle strobe when the stop bit is sampled low
- `parity_error`  out  1  one-cycle strobe on parity mismatch; tied 0 when parity is compiled out
- `busy`  out  1  high in any state except IDLE

## Operation
- Synchroniser: 2 flops, both reset to 1. `rxs` is the second flop output. All decisions use `rxs` only.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. `HALF = CLKS_PER_BIT/2`, using integer division.
- States and transitions:
  - **WAIT_IDLE**: entered from reset and after any error. Move to IDLE when `rxs`=1.
  - **IDLE**: when `rxs`=0, move to START and clear the counter.
  - **START**: at count `HALF-1`, re-sample `rxs`. If 1, treat as a glitch: return to IDLE with no strobe. If 0, move to DATA, clear counter and bit index.
  - **DATA**: every `CLKS_PER_BIT` cycles, sample `rxs` into shift register bit[index], LSB first. After bit 7, move to PARITY (if enabled) or STOP.
  - **PARITY**: sample one bit. Even parity is expected (XOR of data ^ parity = 0). Record any mismatch and move to STOP.
  - **STOP**: sample after `CLKS_PER_BIT` cycles.
    - Stop=1 and no parity mismatch: load `rx_byte`, pulse `rx_byte_valid`, go to IDLE.
    - Stop=1 with parity mismatch: pulse `parity_error`, no valid, `rx_byte` unchanged, go to IDLE.
    - Stop=0: pulse `frame_error` only (no valid, no `parity_error`), `rx_byte` unchanged, go to WAIT_IDLE.
- Back-to-back frames: IDLE is re-entered at the stop-bit mid-point. A start edge arriving during the second half of the stop bit is detected normally.
- Reset mid-frame aborts the frame with no strobe. The block then enters WAIT_IDLE, so trailing low bits of the aborted frame are never taken as a start bit.

## Timing
- T0 = first cycle `rxs`=0 in IDLE, which is 2 cycles after the pin edge.
- Start sample at T0+HALF.
- Data bit i sample at T0+HALF+(i+1)·CLKS_PER_BIT.
- Parity sample at T0+HALF+9·CLKS_PER_BIT.
- Stop sample at T0+HALF+(9+P)·CLKS_PER_BIT, where P=1 with parity, else 0.
- Strobes are registered and asserted in the cycle after the stop sample, for exactly 1 cycle.
- Reset values: `rx_byte`=0x00; `rx_byte_valid`, `frame_error`, `parity_error`, `busy` = 0; state WAIT_IDLE; counter and index = 0.
- No backpressure: the consumer must accept every strobe. The minimum spacing between strobes is (9.5+P)·CLKS_PER_BIT cycles.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is present, frames are 8E1, and `parity_error` is live.
- Undefined: frames are 8N1, there is no PARITY state, and `parity_error` is constant 0.
- The port list is identical in both builds.

## Test plan
- CLKS_PER_BIT=8; send 0xA5 as 8N1 → exactly one `rx_byte_valid` at T0+4+72+1, `rx_byte`=0xA5, no error strobes.
- Back-to-back 0x00 then 0xFF with no idle gap → two valid strobes 80 cycles apart, values 0x00 then 0xFF.
- Pin driven low for 3 cycles while idle → `busy` rises, then returns to 0. No strobes; `rx_byte` is unchanged.
- Frame 0x3C with stop bit low, then line high, then valid frame 0x81 → one `frame_error` strobe with no valid, then a valid strobe with 0x81.
- Assert `rst` during bit 3 of a frame while the line stays low for 20 more cycles, then send 0x42 → no strobe for the aborted frame; one valid strobe with 0x42.
- With `UART_RX_PARITY_EN`: send 0x07 with parity 1 → valid 0x07. Send 0x07 with parity 0 → `parity_error` strobe, no valid, `rx_byte` still 0x07.
